// File: rtl/instr_fetch_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_loader
// Description : Program loader and zero-bubble instruction fetch front end
//               for the single-cycle RV32I core. Bytes arrive little-endian
//               into on-chip instruction memory. Once the program is loaded,
//               one instruction and its PC issue per enabled cycle.
//               Optional macro IFETCH_BOUNDS_CHECK_EN halts fetch when the
//               next PC indexes past the loaded program.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_loader #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,            // asynchronous, active-low
  input  logic        en,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  input  logic        ld_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        restart,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        instr_valid,
  output logic        fetch_err
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  // PRIME is the one-cycle gap between load completion (or restart) and the
  // first valid fetch; it lets the flush write land before mem[0] is read.
  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [31:0]       mem [DEPTH];
  logic [1:0]        byte_cnt;
  logic [23:0]       word_buf;     // lower three bytes of the word being built
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W:0]   word_cnt;

  logic              full;
  logic              accept;
  logic              wr_en;
  logic [31:0]       asm_word;
  logic [31:0]       wr_data;
  logic [31:0]       pc_next;
  logic [ADDR_W-1:0] rd_idx;
  logic              misaligned;
  logic              out_of_bounds;

  assign full     = (word_cnt == FULL_CNT);
  assign ld_ready = (state == S_LOAD) && !full;
  assign accept   = ld_valid && ld_ready;

  // Merge the incoming byte into the pending word at its little-endian lane.
  always_comb begin
    asm_word = {8'h00, word_buf};
    case (byte_cnt)
      2'd0:    asm_word = {24'h00_0000, ld_byte};
      2'd1:    asm_word = {16'h0000, ld_byte, word_buf[7:0]};
      2'd2:    asm_word = {8'h00, ld_byte, word_buf[15:0]};
      default: asm_word = {ld_byte, word_buf};
    endcase
  end

  // A word is committed on its 4th byte, or on ld_done when anything is
  // pending (including a byte accepted in the ld_done cycle), zero-filled.
  assign wr_en   = (state == S_LOAD) &&
                   ((accept && (byte_cnt == 2'd3)) ||
                    (ld_done && (accept || (byte_cnt != 2'd0))));
  assign wr_data = accept ? asm_word : {8'h00, word_buf};

  assign pc_next    = branch_taken ? branch_target : (pc + 32'd4);
  assign rd_idx     = pc_next[ADDR_W+1:2];
  assign misaligned = (pc_next[1:0] != 2'b00);
`ifdef IFETCH_BOUNDS_CHECK_EN
  assign out_of_bounds = ({1'b0, rd_idx} >= word_cnt);
`else
  assign out_of_bounds = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LOAD;
    else      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_LOAD: begin
        if (ld_done) begin
          if ((word_cnt == '0) && !accept && (byte_cnt == 2'd0))
            state_next = S_HALT;
          else
            state_next = S_PRIME;
        end
      end
      S_PRIME: state_next = S_RUN;
      S_RUN: begin
        if (en && (misaligned || out_of_bounds))
          state_next = S_HALT;
      end
      S_HALT: begin
        if (restart)
          state_next = S_PRIME;
      end
      default: state_next = S_LOAD;
    endcase
  end

  // Byte assembly and write-pointer bookkeeping during load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= 2'd0;
      word_buf <= 24'h00_0000;
      wr_idx   <= '0;
      word_cnt <= '0;
    end else if (wr_en) begin
      byte_cnt <= 2'd0;
      word_buf <= 24'h00_0000;
      wr_idx   <= wr_idx + 1'b1;
      word_cnt <= word_cnt + 1'b1;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      word_buf <= asm_word[23:0];
    end
  end

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= wr_data;
  end

  // Fetch path: PC and instruction update together from the same pc_next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= 32'd0;
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      case (state)
        S_PRIME: begin
          pc          <= 32'd0;
          instruction <= mem['0];
          instr_valid <= 1'b1;
        end
        S_RUN: begin
          if (en) begin
            if (misaligned) begin
              fetch_err   <= 1'b1;
              instr_valid <= 1'b0;
              instruction <= NOP_WORD;
            end else if (out_of_bounds) begin
              pc          <= pc_next;
              instr_valid <= 1'b0;
              instruction <= NOP_WORD;
            end else begin
              pc          <= pc_next;
              instruction <= mem[rd_idx];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_loader.md
# instr_fetch_loader

Program-load and instruction-fetch front end for the single-cycle RV32I core. It accepts a program as a little-endian byte stream into an on-chip instruction memory. On the end-of-program marker it begins issuing one instruction per enabled cycle, along with its PC, directly onto the core's `instruction` input. It is the instruction source the core consumes; it replaces bench-driven instructions with a real PC/fetch path.

## Interface
- `ADDR_W`, default 6: word-address width; memory depth is 2**ADDR_W 32-bit words.
- `NOP_WORD`, default 32'h0000_0013: word driven on `instruction` when no valid fetch exists (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: core advance; PC moves only when high in RUN.
- `ld_valid` in 1: load byte present.
- `ld_byte` in 8: load data byte.
- `ld_ready` out 1: loader can accept a byte.
- `ld_done` in 1: single-cycle end-of-program pulse.
- `branch_taken` in 1: redirect request, qualified by `en`.
- `branch_target` in 32: byte address of the redirect.
- `restart` in 1: in HALT, return to RUN at PC 0.
- `instruction` out 32: instruction at `pc`.
- `pc` out 32: byte PC of `instruction`.
- `instr_valid` out 1: `instruction`/`pc` are a real fetch.
- `fetch_err` out 1: sticky misaligned-target flag; cleared only by reset.

## Operation
- States: LOAD (reset state), RUN, HALT.
- LOAD:
  - `ld_ready`=1 unless memory is full.
  - A byte is accepted on `ld_valid && ld_ready`. A 2-bit byte counter places it at bit offset 8*cnt (little-endian).
  - On the 4th byte the word is written at `wr_idx`; `wr_idx` and `word_cnt` increment.
  - Full: after 2**ADDR_W words are written, `ld_ready`=0 and further bytes are not accepted.
  - `ld_done`:
    - If a partial word is pending, it is written with zero-filled upper bytes and counts as one word.
    - If `ld_valid` is accepted in the same cycle, that byte is included before the flush.
    - The FSM then moves to RUN.
  - `ld_done` with `word_cnt`=0 and no pending byte goes directly to HALT.
- RUN:
  - On entry: `pc`=0, `instruction`=mem[0], `instr_valid`=1.
  - Each cycle with `en`=1: `pc_next` = `branch_taken` ? `branch_target` : `pc`+4. Then `pc` <= `pc_next` and `instruction` <= mem[`pc_next`[ADDR_W+1:2]] in the same edge, so fetch has zero bubbles.
  - `en`=0: `pc`, `instruction` and `instr_valid` hold.
  - `branch_taken` is ignored when `en`=0.
  - A `branch_target` with bits [1:0] != 0 sets `fetch_err` and moves to HALT.
  - In RUN, `ld_*` inputs are ignored and `ld_ready`=0.
- HALT:
  - `instr_valid`=0, `instruction`=`NOP_WORD`, `pc` holds its last value.
  - `restart` re-enters RUN exactly as the LOAD→RUN transition does. Memory and `word_cnt` are retained.
- PC arithmetic is 32-bit and wraps modulo 2**32. Memory is indexed by bits [ADDR_W+1:2] only.

## Timing
- Reset values: `ld_ready`=1, `instruction`=`NOP_WORD`, `pc`=0, `instr_valid`=0, `fetch_err`=0, state LOAD, byte counter 0, `wr_idx`=0, `word_cnt`=0. Memory contents are not reset.
- Reset mid-load or mid-run returns to LOAD immediately. Outputs take reset values asynchronously.
- Load write latency: the word is in memory on the edge that accepts its 4th byte.
- The `ld_done` edge performs the flush. The first valid instruction (mem[0]) appears on the next edge, so `instr_valid` rises one cycle after `ld_done`.
- Redirect: the target instruction appears on the same edge that samples `en`&&`branch_taken`. There is no delay slot.
- The memory read is synchronous to the update edge. No combinational path runs from `en`, `branch_taken` or `branch_target` to any output.

## Configuration
- `IFETCH_BOUNDS_CHECK_EN` defined:
  - A `pc_next` with word index ≥ `word_cnt` moves the FSM to HALT instead of fetching, and `pc` still takes `pc_next`.
  - This is the normal end-of-program stop.
- Not defined:
  - No bounds check; the index wraps modulo 2**ADDR_W and RUN continues indefinitely.
  - HALT is reachable only via `ld_done` with an empty program or via a misaligned target.

## Test plan
- Load bytes 13,05,10,00, 93,05,20,00, then `ld_done`; hold `en`=1:
  - mem[0]=32'h00100513 and mem[1]=32'h00200593.
  - `instr_valid` rises one cycle after `ld_done` with `pc`=0.
  - Next edge: `pc`=4, `instruction`=32'h00200593.
- Load 5 bytes (one full word plus byte AA) with `ld_done` in the same cycle as the 5th byte:
  - mem[1]=32'h000000AA and `word_cnt`=2.
- RUN at `pc`=4 with `en`=1, `branch_taken`=1, `branch_target`=0 → next edge `pc`=0, `instruction`=mem[0]. Hold `en`=0 for 3 cycles → all outputs unchanged.
- `branch_target`=32'h6 → `fetch_err`=1, `instr_valid`=0, `instruction`=32'h00000013. Then `restart` → `pc`=0 and `instr_valid`=1, while `fetch_err` stays 1.
- With `IFETCH_BOUNDS_CHECK_EN` and a 2-word program, `en`=1 → HALT on the edge where `pc` becomes 8. Without the macro, `pc` reaches 2**ADDR_W*4 and `instruction` equals mem[0] again.
- Assert `rst`=0 mid-load after 2 bytes, then release and load 4 fresh bytes → the word is written at index 0 with no stale bytes merged in.
